// File: rtl/uart_loader.sv
// UART boot loader: 8N1 receiver packing little-endian 32-bit words into sequential memory writes.
// Optional idle-timeout completion is compiled in with `define UART_IDLE_TIMEOUT_EN.
`ifndef DEFAULT_ROM_DEPTH
`define DEFAULT_ROM_DEPTH 10
`endif

module uart_loader #(
  parameter int ROM_DEPTH    = `DEFAULT_ROM_DEPTH,
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  input  logic               uart_enable,
  output logic               uart_write_enable,
  output logic [31:0]        uart_data,
  output logic [ROM_DEPTH:0] uart_addr,
  output logic               uart_busy,
  output logic               uart_done,
  output logic               frame_error
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 4 || TIMEOUT_BITS < 1) begin : g_bad_param
      $error("uart_loader: CLKS_PER_BIT must be >= 4 and TIMEOUT_BITS >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {LD_OFF, LD_LOAD, LD_FINISH, LD_DONE} ld_state_e;

  // ---------------- receiver ----------------
  logic          rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid, stop_bad;

  always_comb begin
    rx_meta_d  = rx;
    rx_sync_d  = rx_meta_q;
    rx_prev_d  = rx_sync_q;
    rx_state_d = rx_state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    stop_bad   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          clk_cnt_d  = '0;
        end
      end
      RX_START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d  = '0;
          bit_cnt_d  = '0;
          // A line already back high mid-start-bit was only a glitch.
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == CNT_FULL) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
          else                   bit_cnt_d  = bit_cnt_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == CNT_FULL) begin
          rx_state_d = RX_IDLE;
          byte_valid = rx_sync_q;
          stop_bad   = !rx_sync_q;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
    end
  end

  // ---------------- loader ----------------
  ld_state_e      ld_state_q, ld_state_d;
  logic           en_prev_q, en_prev_d;
  logic [ROM_DEPTH:0] addr_q, addr_d;
  logic [1:0]     byte_idx_q, byte_idx_d;
  logic [31:0]    word_q, word_d, word_next;
  logic [31:0]    data_q, data_d;
  logic           we_q, we_d, busy_q, busy_d, done_q, done_d, ferr_q, ferr_d;
`ifdef UART_IDLE_TIMEOUT_EN
  localparam logic [31:0] IDLE_LIMIT = 32'(TIMEOUT_BITS * CLKS_PER_BIT);
  logic           have_byte_q, have_byte_d;
  logic [31:0]    idle_cnt_q, idle_cnt_d;
`endif

  always_comb begin
    ld_state_d = ld_state_q;
    en_prev_d  = uart_enable;
    addr_d     = addr_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    data_d     = data_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    ferr_d     = ferr_q | stop_bad;
    word_next  = word_q;
    word_next[{byte_idx_q, 3'b000} +: 8] = shift_q;
`ifdef UART_IDLE_TIMEOUT_EN
    have_byte_d = have_byte_q;
    idle_cnt_d  = idle_cnt_q;
`endif
    case (ld_state_q)
      LD_OFF: begin
        if (uart_enable && !en_prev_q) begin
          ld_state_d = LD_LOAD;
          addr_d     = '0;
          byte_idx_d = '0;
          word_d     = '0;
          ferr_d     = 1'b0;
`ifdef UART_IDLE_TIMEOUT_EN
          have_byte_d = 1'b0;
          idle_cnt_d  = '0;
`endif
        end
      end
      LD_LOAD: begin
        if (!uart_enable) begin
          // Abort: partial word and any byte landing this cycle are dropped.
          ld_state_d = LD_OFF;
        end else if (byte_valid) begin
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef UART_IDLE_TIMEOUT_EN
          have_byte_d = 1'b1;
          idle_cnt_d  = '0;
`endif
          if (byte_idx_q == 2'd3) begin
            we_d   = 1'b1;
            data_d = word_next;
            word_d = '0;
            if (addr_q == '1) ld_state_d = LD_FINISH;
            else              addr_d     = addr_q + 1'b1;
          end else begin
            word_d = word_next;
          end
        end
`ifdef UART_IDLE_TIMEOUT_EN
        else if (have_byte_q) begin
          if (idle_cnt_q == IDLE_LIMIT - 32'd1) begin
            if (byte_idx_q != 2'd0) begin
              we_d       = 1'b1;
              data_d     = word_q;
              word_d     = '0;
              ld_state_d = LD_FINISH;
            end else begin
              done_d     = 1'b1;
              ld_state_d = LD_DONE;
            end
          end else begin
            idle_cnt_d = idle_cnt_q + 32'd1;
          end
        end
`endif
      end
      LD_FINISH: begin
        // One cycle after the final write: pulse done.
        done_d     = 1'b1;
        ld_state_d = LD_DONE;
      end
      LD_DONE: begin
        if (!uart_enable) ld_state_d = LD_OFF;
      end
      default: ld_state_d = LD_OFF;
    endcase
    busy_d = (ld_state_d == LD_LOAD) || (ld_state_d == LD_FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state_q <= LD_OFF;
      en_prev_q  <= 1'b1;
      addr_q     <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_IDLE_TIMEOUT_EN
      have_byte_q <= 1'b0;
      idle_cnt_q  <= '0;
`endif
    end else begin
      ld_state_q <= ld_state_d;
      en_prev_q  <= en_prev_d;
      addr_q     <= addr_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      data_q     <= data_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
`ifdef UART_IDLE_TIMEOUT_EN
      have_byte_q <= have_byte_d;
      idle_cnt_q  <= idle_cnt_d;
`endif
    end
  end

  // The address register advances after each strobe, so the presented address is latched with the data.
  logic [ROM_DEPTH:0] out_addr_q, out_addr_d;
  always_comb begin
    out_addr_d = out_addr_q;
    if (we_d) out_addr_d = addr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_addr_q <= '0;
    else     out_addr_q <= out_addr_d;
  end

  assign uart_write_enable = we_q;
  assign uart_data         = data_q;
  assign uart_addr         = out_addr_q;
  assign uart_busy         = busy_q;
  assign uart_done         = done_q;
  assign frame_error       = ferr_q;

endmodule

// File: tb/tb_uart_loader.sv
// Randomised bench for uart_loader: byte-level reference model feeds a scoreboard checked by a monitor.
module tb_uart_loader;
  localparam int CPB    = 4;
  localparam int RD     = 2;
  localparam int NWORDS = 1 << (RD + 1);

  logic        clk = 1'b0, rst = 1'b1, rx = 1'b1, uart_enable = 1'b0;
  logic        uart_write_enable, uart_busy, uart_done, frame_error;
  logic [31:0] uart_data;
  logic [RD:0] uart_addr;

  uart_loader #(.ROM_DEPTH(RD), .CLKS_PER_BIT(CPB), .TIMEOUT_BITS(64)) dut (
    .clk(clk), .rst(rst), .rx(rx), .uart_enable(uart_enable),
    .uart_write_enable(uart_write_enable), .uart_data(uart_data), .uart_addr(uart_addr),
    .uart_busy(uart_busy), .uart_done(uart_done), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {bit is_done; logic [RD:0] addr; logic [31:0] data;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0, errors = 0;
  int last_we_cyc = -100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Reference model: a granted load is a stream of good bytes grouped in fours.
  logic [7:0] pend[$];
  int  m_addr = 0;
  bit  m_granted = 0;

  task automatic push_write(input logic [31:0] w);
    exp_t e;
    e.is_done = 0; e.addr = m_addr[RD:0]; e.data = w;
    exp_q.push_back(e);
    m_addr++;
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1; e.addr = '0; e.data = '0;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] w;
    if (!m_granted) return;
    pend.push_back(b);
    if (pend.size() == 4) begin
      w = 32'd0;
      for (int i = 0; i < 4; i++) w = w | (32'(pend[i]) << (8 * i));
      pend.delete();
      push_write(w);
      if (m_addr == NWORDS) push_done();
    end
  endtask

  task automatic model_flush();
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < pend.size(); i++) w = w | (32'(pend[i]) << (8 * i));
    if (pend.size() != 0) push_write(w);
    pend.delete();
    push_done();
  endtask

  task automatic grant();
    uart_enable = 1'b1;
    m_granted = 1; m_addr = 0; pend.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic ungrant();
    uart_enable = 1'b0;
    m_granted = 0; pend.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    if (!bad_stop) model_byte(b);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_we"},   uart_write_enable, 0);
    chk({tag, "_data"}, uart_data, 0);
    chk({tag, "_addr"}, uart_addr, 0);
    chk({tag, "_busy"}, uart_busy, 0);
    chk({tag, "_done"}, uart_done, 0);
    chk({tag, "_ferr"}, frame_error, 0);
  endtask

  // Monitor: every write and done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (uart_write_enable) begin
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write", uart_addr, uart_data);
        end else begin
          mon_e = exp_q.pop_front();
          $display("write addr=%0d data=0x%08h (expected addr=%0d data=0x%08h)", uart_addr, uart_data, mon_e.addr, mon_e.data);
          chk("write_addr", uart_addr, mon_e.addr);
          chk("write_data", uart_data, mon_e.data);
          chk("busy_at_write", uart_busy, 1);
        end
        last_we_cyc = cyc;
      end
      if (uart_done) begin
        if (exp_q.size() == 0 || !exp_q[0].is_done) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done pulse at cycle %0d, expected none", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          $display("done at cycle %0d (last write cycle %0d)", cyc, last_we_cyc);
          chk("done_latency", cyc - last_we_cyc, 1);
          chk("busy_at_done", uart_busy, 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-frame during a load, then bytes without a grant.
    grant();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    m_granted = 0; pend.delete();
    #1;
    chk_outputs_zero("midreset");
    rx = 1'b1; uart_enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    repeat (5) @(negedge clk);
    chk("nogrant_busy", uart_busy, 0);

    // Single word.
    grant();
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    drain(100);
    chk("single_busy", uart_busy, 1);
    ungrant();

    // Full load of random bytes.
    grant();
    for (int i = 0; i < 4 * NWORDS; i++) begin
      send_byte(8'($urandom), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain(200);
    chk("full_busy_after", uart_busy, 0);
    chk("full_ferr", frame_error, 0);
    ungrant();

    // Glitch, then a bad stop bit on the second byte.
    grant();
    rx = 1'b0; @(negedge clk); rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      send_byte(b, i == 1);
    end
    drain(100);
    chk("ferr_set", frame_error, 1);
    ungrant();

    // Abort after two bytes, then fresh load.
    grant();
    chk("ferr_cleared", frame_error, 0);
    send_byte(8'($urandom), 0);
    send_byte(8'($urandom), 0);
    ungrant();
    chk("abort_busy", uart_busy, 0);
    grant();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    drain(100);
    chk("regrant_ferr", frame_error, 0);
    ungrant();

    // Idle timeout behaviour after two bytes.
    grant();
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
`ifdef UART_IDLE_TIMEOUT_EN
    model_flush();
    drain(64 * CPB + 100);
`else
    repeat (64 * CPB + 40) @(negedge clk);
    chk("notimeout_busy", uart_busy, 1);
`endif
    ungrant();

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
